// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the E stage. Owns HI/LO, computes the
// result on the start edge into a pending register, and releases it to
// HI/LO after a fixed latency modelled by a busy countdown.
module mdu_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic        md_use_E,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic {StIdle, StRun} state_e;

  state_e           r_state;
  logic [CntW-1:0]  r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [63:0]      r_pend;
  logic             r_pend_skip;

  logic             w_start;
  logic             w_is_div;
  logic             w_signed;
  logic [63:0]      w_mul_a;
  logic [63:0]      w_mul_b;
  logic [63:0]      w_prod;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [31:0]      w_dvd;
  logic [31:0]      w_dvs;
  logic             w_div0;
  logic [31:0]      w_uq;
  logic [31:0]      w_ur;
  logic [31:0]      w_q;
  logic [31:0]      w_r;
  logic [63:0]      w_res;

  // Decode a start: only from IDLE, so a command held during RUN never restarts.
  always_comb begin
    w_start  = 1'b0;
    w_is_div = 1'b0;
    w_signed = 1'b0;
    if (r_state == StIdle) begin
      case (md_op)
        OpMult:  begin w_start = 1'b1; w_signed = 1'b1; end
        OpMultu: begin w_start = 1'b1; end
        OpDiv:   begin w_start = 1'b1; w_is_div = 1'b1; w_signed = 1'b1; end
        OpDivu:  begin w_start = 1'b1; w_is_div = 1'b1; end
        default: ;
      endcase
    end
  end

  // Multiplier: sign- or zero-extend to 64 bits; the low 64 bits of the
  // product are correct for both signed and unsigned operands.
  always_comb begin
    w_mul_a = w_signed ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
    w_mul_b = w_signed ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
    w_prod  = w_mul_a * w_mul_b;
  end

  // Divider: one unsigned core on magnitudes, signs fixed up afterwards.
  // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
  always_comb begin
    w_a_neg = w_signed & src_a[31];
    w_b_neg = w_signed & src_b[31];
    w_dvd   = w_a_neg ? (32'd0 - src_a) : src_a;
    w_dvs   = w_b_neg ? (32'd0 - src_b) : src_b;
    w_div0  = (src_b == 32'd0);
    if (w_div0) begin
      w_uq = 32'd0;
      w_ur = 32'd0;
    end else begin
      w_uq = w_dvd / w_dvs;
      w_ur = w_dvd % w_dvs;
    end
    w_q   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
    w_r   = w_a_neg ? (32'd0 - w_ur) : w_ur;
    w_res = w_is_div ? {w_r, w_q} : w_prod;
  end

  // Control FSM with registered HI/LO, busy and done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_pend      <= 64'd0;
      r_pend_skip <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_pend      <= w_res;
            // Divide by zero still runs the full latency but leaves HI/LO alone.
            r_pend_skip <= w_is_div & w_div0;
            r_cnt       <= w_is_div ? CntW'(DIV_LAT) : CntW'(MULT_LAT);
            r_busy      <= 1'b1;
            r_state     <= StRun;
          end else if (md_op == OpMthi) begin
            r_hi <= src_a;
          end else if (md_op == OpMtlo) begin
            r_lo <= src_a;
          end
        end
        StRun: begin
          r_cnt <= r_cnt - CntW'(1);
          if (r_cnt == CntW'(1)) begin
            if (!r_pend_skip) begin
              r_hi <= r_pend[63:32];
              r_lo <= r_pend[31:0];
            end
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // The starter itself advances; only a later HI/LO user sees busy and stalls.
  assign stall_req = md_use_E & r_busy;
  assign busy      = r_busy;
  assign done      = r_done;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: a table of single operations with
// hand-computed HI/LO and latency, plus sequences for the held
// back-to-back case, mflo stall check and reset-abort.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  md_op;
  logic        md_use_E;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  mdu_ctrl #(
    .MULT_LAT(5),
    .DIV_LAT (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .md_op    (md_op),
    .md_use_E (md_use_E),
    .src_a    (src_a),
    .src_b    (src_b),
    .busy     (busy),
    .stall_req(stall_req),
    .hi       (hi),
    .lo       (lo),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one command for a single cycle, then wait out any latency.
  task automatic run_op(input vec_t v);
    int cnt;
    @(negedge clk);
    md_op = v.op; md_use_E = 1'b1; src_a = v.a; src_b = v.b;
    #1 chk({v.nm, "_stall_start"}, 32'(stall_req), 32'd0);
    @(negedge clk);
    md_op = 3'd0; md_use_E = 1'b0;
    if (v.lat == 0) begin
      chk({v.nm, "_busy"}, 32'(busy), 32'd0);
      chk({v.nm, "_done"}, 32'(done), 32'd0);
    end else begin
      cnt = 0;
      while (busy && cnt < 40) begin
        cnt++;
        @(negedge clk);
      end
      chk({v.nm, "_lat"}, 32'(cnt), 32'(v.lat));
      chk({v.nm, "_done"}, 32'(done), 32'd1);
    end
    chk({v.nm, "_hi"}, hi, v.exp_hi);
    chk({v.nm, "_lo"}, lo, v.exp_lo);
    @(negedge clk);
    chk({v.nm, "_done_end"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cnt;
    bit any_done;
    bit stall_ok;

    // Operations apply in order; HI/LO carry over between entries.
    vecs.push_back('{"mthi_abcd", 3'd5, 32'h0000ABCD, 32'h0, 32'h0000ABCD, 32'h0, 0});
    vecs.push_back('{"mtlo_1234", 3'd6, 32'h00001234, 32'h0, 32'h0000ABCD, 32'h00001234, 0});
    vecs.push_back('{"nop7", 3'd7, 32'hDEADBEEF, 32'h1, 32'h0000ABCD, 32'h00001234, 0});
    vecs.push_back('{"mult_m3x5", 3'd1, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5});
    vecs.push_back('{"multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 5});
    vecs.push_back('{"mult_maxpos", 3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h1, 5});
    vecs.push_back('{"div_7_m2", 3'd3, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 10});
    vecs.push_back('{"div_min_m1", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10});
    vecs.push_back('{"divu_big", 3'd4, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 10});
    vecs.push_back('{"mthi_11", 3'd5, 32'h11, 32'h0, 32'h11, 32'h0FFFFFFF, 0});
    vecs.push_back('{"mtlo_22", 3'd6, 32'h22, 32'h0, 32'h11, 32'h22, 0});
    vecs.push_back('{"div_by0", 3'd3, 32'h5, 32'h0, 32'h11, 32'h22, 10});
    vecs.push_back('{"divu_by0", 3'd4, 32'hFFFFFFFF, 32'h0, 32'h11, 32'h22, 10});

    reset = 1'b0; md_op = 3'd0; md_use_E = 1'b0; src_a = 32'd0; src_b = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

    // mflo in E while idle must not stall.
    @(negedge clk);
    md_use_E = 1'b1;
    #1 chk("mflo_idle_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    md_use_E = 1'b0;

    // divu 7/2 followed by div -7/2 held in E during the first op.
    @(negedge clk);
    md_op = 3'd4; md_use_E = 1'b1; src_a = 32'd7; src_b = 32'd2;
    @(negedge clk);
    md_op = 3'd3; src_a = 32'hFFFFFFF9; src_b = 32'd2;
    cnt = 0; stall_ok = 1'b1;
    while (busy && cnt < 40) begin
      if (!stall_req) stall_ok = 1'b0;
      cnt++;
      @(negedge clk);
    end
    chk("b2b_first_lat", 32'(cnt), 32'd10);
    chk("b2b_stall_held", 32'(stall_ok), 32'd1);
    chk("b2b_first_hi", hi, 32'd1);
    chk("b2b_first_lo", lo, 32'd3);
    chk("b2b_first_done", 32'(done), 32'd1);
    chk("b2b_release", 32'(stall_req), 32'd0);
    @(negedge clk);
    md_op = 3'd0; md_use_E = 1'b0;
    chk("b2b_second_busy", 32'(busy), 32'd1);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("b2b_second_lat", 32'(cnt), 32'd10);
    chk("b2b_second_hi", hi, 32'hFFFFFFFF);
    chk("b2b_second_lo", lo, 32'hFFFFFFFD);
    repeat (2) @(negedge clk);
    chk("b2b_no_restart", 32'(busy), 32'd0);

    // multu aborted by reset in its third busy cycle.
    @(negedge clk);
    md_op = 3'd2; md_use_E = 1'b1; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
    @(negedge clk);
    md_op = 3'd0; md_use_E = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    any_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) any_done = 1'b1;
    end
    chk("abort_no_done", 32'(any_done), 32'd0);
    chk("abort_hi_after", hi, 32'd0);
    chk("abort_lo_after", lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
